// File: rtl/alu_mul_seq_if.sv
// Bundle for the multiply sequencer: the request/result handshake and the ALU drive/return lines.
// With MULT_SIGNED_EN defined it also carries signed_op.
interface alu_mul_seq_if;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
`ifdef MULT_SIGNED_EN
  logic        signed_op;
`endif
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_gin;
  logic [31:0] alu_result;

`ifdef MULT_SIGNED_EN
  modport master (output start, op_a, op_b, signed_op, alu_result,
                  input  busy, done, hi, lo, alu_a, alu_b, alu_gin);
  modport slave  (input  start, op_a, op_b, signed_op, alu_result,
                  output busy, done, hi, lo, alu_a, alu_b, alu_gin);
`else
  modport master (output start, op_a, op_b, alu_result,
                  input  busy, done, hi, lo, alu_a, alu_b, alu_gin);
  modport slave  (input  start, op_a, op_b, alu_result,
                  output busy, done, hi, lo, alu_a, alu_b, alu_gin);
`endif
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add 32x32->64 multiply sequencer that borrows the external alu32 for every add.
// Optional MULT_SIGNED_EN: two's-complement operands handled by negating before and after MUL.
module alu_mul_seq #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic         clk,
  input  logic         reset,
  alu_mul_seq_if.slave bus
);
  localparam int CW = $clog2(ITER) + 1;
  localparam logic [2:0] GIN_ADD = 3'b010;
  localparam logic [2:0] GIN_SUB = 3'b110;
  localparam logic [2:0] GIN_NOR = 3'b011;

`ifdef MULT_SIGNED_EN
  typedef enum logic [2:0] {IDLE, MUL, FIN, NEGA, NEGB, NEGL, NEGH} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;
`endif

  state_t           state_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] mcand_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] alu_a_s;
  logic [WIDTH-1:0] alu_b_s;
  logic [2:0]       alu_gin_s;
  logic             carry_s;
`ifdef MULT_SIGNED_EN
  logic             sop_r;
  logic             neg_r;
  logic             lz_r;
`endif

  // ALU operand/control drive decoded from the current state
  always_comb begin
    alu_a_s   = 32'd0;
    alu_b_s   = 32'd0;
    alu_gin_s = GIN_ADD;
    case (state_r)
      IDLE: alu_gin_s = GIN_ADD;
      MUL:  begin
        alu_a_s = hi_r;
        if (lo_r[0]) alu_b_s = mcand_r;
        else         alu_b_s = 32'd0;
      end
      FIN:  alu_gin_s = GIN_ADD;
`ifdef MULT_SIGNED_EN
      NEGA: begin alu_b_s = mcand_r; alu_gin_s = GIN_SUB; end
      NEGB: begin alu_b_s = lo_r;    alu_gin_s = GIN_SUB; end
      NEGL: begin alu_b_s = lo_r;    alu_gin_s = GIN_SUB; end
      // Upper word of a 64-bit negate: borrow only propagates when the low word was zero
      NEGH: begin
        if (lz_r) begin
          alu_b_s   = hi_r;
          alu_gin_s = GIN_SUB;
        end else begin
          alu_a_s   = hi_r;
          alu_b_s   = hi_r;
          alu_gin_s = GIN_NOR;
        end
      end
`endif
      default: alu_gin_s = GIN_ADD;
    endcase
  end

  // Carry out of the 32-bit add, recovered from the operand and result sign bits
  always_comb begin
    carry_s = (alu_a_s[WIDTH-1] & alu_b_s[WIDTH-1]) |
              ((alu_a_s[WIDTH-1] | alu_b_s[WIDTH-1]) & ~bus.alu_result[WIDTH-1]);
  end

  // Sequencer state, product registers and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      mcand_r <= 32'd0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef MULT_SIGNED_EN
      sop_r   <= 1'b0;
      neg_r   <= 1'b0;
      lz_r    <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            mcand_r <= bus.op_a;
            lo_r    <= bus.op_b;
            hi_r    <= 32'd0;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
`ifdef MULT_SIGNED_EN
            sop_r   <= bus.signed_op;
            neg_r   <= bus.signed_op & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
            state_r <= NEGA;
`else
            state_r <= MUL;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        MUL: begin
          hi_r  <= {carry_s, bus.alu_result[WIDTH-1:1]};
          lo_r  <= {bus.alu_result[0], lo_r[WIDTH-1:1]};
          cnt_r <= cnt_r + 1'b1;
          if (cnt_r == CW'(ITER - 1)) begin
`ifdef MULT_SIGNED_EN
            state_r <= NEGL;
`else
            state_r <= FIN;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
`endif
          end else begin
            state_r <= MUL;
          end
        end
        FIN: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
`ifdef MULT_SIGNED_EN
        NEGA: begin
          if (sop_r & mcand_r[WIDTH-1]) mcand_r <= bus.alu_result;
          state_r <= NEGB;
        end
        NEGB: begin
          if (sop_r & lo_r[WIDTH-1]) lo_r <= bus.alu_result;
          state_r <= MUL;
        end
        NEGL: begin
          lz_r <= (lo_r == 32'd0);
          if (neg_r) lo_r <= bus.alu_result;
          state_r <= NEGH;
        end
        NEGH: begin
          if (neg_r) hi_r <= bus.alu_result;
          state_r <= FIN;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
        end
`endif
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.alu_a   = alu_a_s;
  assign bus.alu_b   = alu_b_s;
  assign bus.alu_gin = alu_gin_s;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.hi      = hi_r;
  assign bus.lo      = lo_r;
endmodule
